otl_capture_ctrl: RTL and testbench

Capture sequencer for the packed RX sample stream. Sits directly after the 12-bit-to-32-bit packer and takes its packed words plus word strobe. On a software arm, with an optional trigger, it captures exactly `len_i` words into a small first-word-fall-through FIFO and streams them downstream over valid/ready. It flags the final word, reports completion and records overflow.

---
 rtl/otl_capture_ctrl.sv | 116 +++++++++++
 tb/tb_otl_capture_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otl_capture_ctrl.sv
// Capture sequencer: arms on software request, optionally waits for a trigger,
// stores exactly len_i packed words in a FWFT FIFO and streams them out.
module otl_capture_ctrl #(
   parameter int DEPTH_LOG2 = 3,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             trig_mode_i,
   input  logic             trig_i,
   input  logic [31:0]      data_i,
   input  logic             frame_i,
   output logic [31:0]      data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             last_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_o,
   output logic [LEN_W-1:0] count_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;
   localparam logic [LEN_W-1:0]    CNT_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_CAPTURE, S_DRAIN} state_t;

   state_t              r_state, w_state_nxt;
   logic [DEPTH_LOG2:0] r_wptr, r_rptr;
   logic [32:0]         r_mem [DEPTH];
   logic [LEN_W-1:0]    r_len, r_cnt;
   logic                r_ovf, r_done;

   logic [32:0]      w_head;
   logic [LEN_W-1:0] w_cnt_inc;
   logic             w_empty, w_full, w_pop, w_cap, w_push, w_drop;
   logic             w_final, w_arm_ok, w_final_pop;

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                      (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
   assign w_head    = r_mem[r_rptr[DEPTH_LOG2-1:0]];
   // Abort wins over every other action in the same cycle.
   assign w_pop     = !w_empty && ready_i && !abort_i;
   assign w_cap     = (r_state == S_CAPTURE) && frame_i && !abort_i;
   assign w_push    = w_cap && !w_full;
   assign w_drop    = w_cap && w_full;
   assign w_cnt_inc = r_cnt + CNT_ONE;
   assign w_final   = w_push && (w_cnt_inc == r_len);
   assign w_arm_ok  = (r_state == S_IDLE) && arm_i && (len_i != '0) && !abort_i;
   assign w_final_pop = (r_state == S_DRAIN) && w_pop && w_head[32];

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (abort_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:      if (w_arm_ok) w_state_nxt = trig_mode_i ? S_WAIT_TRIG : S_CAPTURE;
            S_WAIT_TRIG: if (trig_i) w_state_nxt = S_CAPTURE;
            S_CAPTURE:   if (w_final) w_state_nxt = S_DRAIN;
            S_DRAIN:     if (w_final_pop) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_len  <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_final_pop;
         if (abort_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         end
         if (w_arm_ok) begin
            r_len <= len_i;
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else begin
            if (w_push) r_cnt <= w_cnt_inc;
            if (w_drop) r_ovf <= 1'b1;
         end
      end
   end

   // Storage is not reset; contents are only observed through valid_o.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= {w_final, data_i};
   end

   assign valid_o = !w_empty;
   assign data_o  = valid_o ? w_head[31:0] : 32'h0;
   assign last_o  = valid_o && w_head[32];
   assign busy_o  = (r_state != S_IDLE);
   assign done_o  = r_done;
   assign ovf_o   = r_ovf;
   assign count_o = r_cnt;
endmodule

// File: tb/tb_otl_capture_ctrl.sv
// Scoreboard bench for otl_capture_ctrl: expected words queued as stimulus is
// driven, popped and compared whenever the DUT hands a word downstream.
module tb_otl_capture_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, arm_i, abort_i, trig_mode_i, trig_i, frame_i, ready_i;
   logic [15:0] len_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        valid_o, last_o, busy_o, done_o, ovf_o;
   logic [15:0] count_o;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int pop_cnt = 0;
   logic [32:0] exp_q[$];

   otl_capture_ctrl #(.DEPTH_LOG2(3), .LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .abort_i(abort_i), .len_i(len_i),
      .trig_mode_i(trig_mode_i), .trig_i(trig_i), .data_i(data_i), .frame_i(frame_i),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
      .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   // Inputs only change 1 time unit after a rising edge, so the negedge sees
   // exactly the values the next rising edge will use.
   always @(negedge clk) begin
      logic [32:0] e;
      if (done_o) done_cnt++;
      if (rst_n && valid_o && ready_i) begin
         pop_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pop got data=%h last=%0b required no word", data_o, last_o);
         end else begin
            e = exp_q.pop_front();
            if ({last_o, data_o} !== e)
               begin failures++; $display("FAIL pop_word got last=%0b data=%h required last=%0b data=%h", last_o, data_o, e[32], e[31:0]); end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (exp_q.size() == 0 && !busy_o && !valid_o) begin ok = 1'b1; break; end
      end
      tick();
   endtask

   task automatic arm(input logic [15:0] len, input logic mode);
      arm_i = 1'b1; len_i = len; trig_mode_i = mode;
      tick();
      arm_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({valid_o, data_o, last_o, busy_o, done_o, ovf_o, count_o} !== 53'h0) begin
         failures++;
         $display("FAIL reset_state got v=%0b d=%h l=%0b b=%0b dn=%0b o=%0b c=%0d required all zero",
                  valid_o, data_o, last_o, busy_o, done_o, ovf_o, count_o);
      end
      tick();
   endtask

   task automatic test_immediate();
      bit ok;
      done_cnt = 0; ready_i = 1'b1;
      arm(16'd5, 1'b0);
      checks++;
      if (busy_o !== 1'b1) begin failures++; $display("FAIL imm_busy got %0b required 1", busy_o); end
      for (int k = 0; k < 5; k++) begin
         frame_i = 1'b1; data_i = 32'hAAA + k;
         exp_q.push_back({(k == 4), 32'hAAA + k});
         tick();
         frame_i = 1'b0;
         tick();
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL imm_timeout got busy=%0b q=%0d required idle", busy_o, exp_q.size()); end
      checks++;
      if ({done_cnt, ovf_o, count_o} !== {32'd1, 1'b0, 16'd5})
         begin failures++; $display("FAIL imm_flags got done=%0d ovf=%0b cnt=%0d required 1 0 5", done_cnt, ovf_o, count_o); end
   endtask

   task automatic test_trigger();
      bit ok;
      done_cnt = 0; ready_i = 1'b1;
      frame_i = 1'b1; data_i = 32'h0FF;
      arm(16'd3, 1'b1);
      for (int c = 0; c < 10; c++) begin
         data_i = 32'h100 + c;
         trig_i = (c == 3);
         if (c >= 4 && c <= 6) exp_q.push_back({(c == 6), 32'h100 + c});
         if (c == 2) begin
            checks++;
            if ({busy_o, valid_o} !== 2'b10) begin failures++; $display("FAIL trig_wait got busy=%0b valid=%0b required 1 0", busy_o, valid_o); end
         end
         tick();
      end
      trig_i = 1'b0; frame_i = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL trig_timeout got busy=%0b q=%0d required idle", busy_o, exp_q.size()); end
      checks++;
      if ({done_cnt, count_o} !== {32'd1, 16'd3})
         begin failures++; $display("FAIL trig_flags got done=%0d cnt=%0d required 1 3", done_cnt, count_o); end
   endtask

   task automatic test_overflow();
      bit ok;
      done_cnt = 0; ready_i = 1'b0;
      arm(16'd12, 1'b0);
      for (int c = 0; c < 10; c++) begin
         frame_i = 1'b1; data_i = 32'h200 + c;
         if (c < 8) exp_q.push_back({1'b0, 32'h200 + c});
         tick();
      end
      frame_i = 1'b0;
      checks++;
      if ({ovf_o, count_o, valid_o, busy_o} !== {1'b1, 16'd8, 1'b1, 1'b1})
         begin failures++; $display("FAIL ovf_fill got ovf=%0b cnt=%0d v=%0b b=%0b required 1 8 1 1", ovf_o, count_o, valid_o, busy_o); end
      ready_i = 1'b1;
      repeat (10) tick();
      for (int c = 0; c < 4; c++) begin
         frame_i = 1'b1; data_i = 32'h300 + c;
         exp_q.push_back({(c == 3), 32'h300 + c});
         tick();
      end
      frame_i = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok || done_cnt != 1 || count_o !== 16'd12)
         begin failures++; $display("FAIL ovf_finish got ok=%0b done=%0d cnt=%0d required 1 1 12", ok, done_cnt, count_o); end
   endtask

   task automatic test_full_pop();
      bit ok;
      done_cnt = 0; ready_i = 1'b0;
      arm(16'd12, 1'b0);
      checks++;
      if ({ovf_o, count_o} !== 17'h0) begin failures++; $display("FAIL fp_arm_clear got ovf=%0b cnt=%0d required 0 0", ovf_o, count_o); end
      for (int c = 0; c < 8; c++) begin
         frame_i = 1'b1; data_i = 32'h400 + c;
         exp_q.push_back({1'b0, 32'h400 + c});
         tick();
      end
      checks++;
      if ({ovf_o, count_o} !== {1'b0, 16'd8}) begin failures++; $display("FAIL fp_full got ovf=%0b cnt=%0d required 0 8", ovf_o, count_o); end
      data_i = 32'h4F0; ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      checks++;
      if ({ovf_o, count_o} !== {1'b1, 16'd8}) begin failures++; $display("FAIL fp_simul got ovf=%0b cnt=%0d required 1 8", ovf_o, count_o); end
      data_i = 32'h4F1; exp_q.push_back({1'b0, 32'h4F1});
      tick();
      checks++;
      if (count_o !== 16'd9) begin failures++; $display("FAIL fp_room got cnt=%0d required 9", count_o); end
      data_i = 32'h4F2;
      tick();
      checks++;
      if (count_o !== 16'd9) begin failures++; $display("FAIL fp_refull got cnt=%0d required 9", count_o); end
      frame_i = 1'b0; ready_i = 1'b1;
      repeat (10) tick();
      for (int c = 3; c < 6; c++) begin
         frame_i = 1'b1; data_i = 32'h4F0 + c;
         exp_q.push_back({(c == 5), 32'h4F0 + c});
         tick();
      end
      frame_i = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok || done_cnt != 1 || count_o !== 16'd12 || ovf_o !== 1'b1)
         begin failures++; $display("FAIL fp_finish got ok=%0b done=%0d cnt=%0d ovf=%0b required 1 1 12 1", ok, done_cnt, count_o, ovf_o); end
   endtask

   task automatic test_ignored_arm();
      bit ok;
      done_cnt = 0; ready_i = 1'b0;
      arm(16'd0, 1'b0);
      checks++;
      if ({busy_o, ovf_o, count_o} !== {1'b0, 1'b1, 16'd12})
         begin failures++; $display("FAIL arm_len0 got b=%0b ovf=%0b cnt=%0d required 0 1 12", busy_o, ovf_o, count_o); end
      arm(16'd4, 1'b0);
      checks++;
      if ({busy_o, ovf_o, count_o} !== {1'b1, 1'b0, 16'd0})
         begin failures++; $display("FAIL arm_ok got b=%0b ovf=%0b cnt=%0d required 1 0 0", busy_o, ovf_o, count_o); end
      frame_i = 1'b1; data_i = 32'h500; exp_q.push_back({1'b0, 32'h500});
      tick();
      arm_i = 1'b1; len_i = 16'd1; trig_mode_i = 1'b1;
      data_i = 32'h501; exp_q.push_back({1'b0, 32'h501});
      tick();
      arm_i = 1'b0;
      for (int c = 2; c < 4; c++) begin
         data_i = 32'h500 + c; exp_q.push_back({(c == 3), 32'h500 + c});
         tick();
      end
      frame_i = 1'b0;
      checks++;
      if ({busy_o, count_o} !== {1'b1, 16'd4}) begin failures++; $display("FAIL arm_busy got b=%0b cnt=%0d required 1 4", busy_o, count_o); end
      ready_i = 1'b1;
      wait_idle(ok);
      checks++;
      if (!ok || done_cnt != 1) begin failures++; $display("FAIL arm_finish got ok=%0b done=%0d required 1 1", ok, done_cnt); end
   endtask

   task automatic test_abort();
      bit ok;
      done_cnt = 0; ready_i = 1'b0;
      arm(16'd10, 1'b0);
      for (int c = 0; c < 2; c++) begin
         frame_i = 1'b1; data_i = 32'h600 + c; exp_q.push_back({1'b0, 32'h600 + c});
         tick();
      end
      abort_i = 1'b1; arm_i = 1'b1; data_i = 32'h602;
      tick();
      abort_i = 1'b0; arm_i = 1'b0; frame_i = 1'b0;
      exp_q.delete();
      checks++;
      if ({valid_o, busy_o, data_o, count_o, ovf_o} !== {1'b0, 1'b0, 32'h0, 16'd2, 1'b0})
         begin failures++; $display("FAIL abort_state got v=%0b b=%0b d=%h cnt=%0d ovf=%0b required 0 0 0 2 0", valid_o, busy_o, data_o, count_o, ovf_o); end
      tick(); tick();
      checks++;
      if (done_cnt != 0) begin failures++; $display("FAIL abort_nodone got %0d required 0", done_cnt); end
      ready_i = 1'b1;
      arm(16'd2, 1'b0);
      for (int c = 0; c < 2; c++) begin
         frame_i = 1'b1; data_i = 32'h610 + c; exp_q.push_back({(c == 1), 32'h610 + c});
         tick();
      end
      frame_i = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok || done_cnt != 1 || count_o !== 16'd2)
         begin failures++; $display("FAIL abort_rearm got ok=%0b done=%0d cnt=%0d required 1 1 2", ok, done_cnt, count_o); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit seen;
      done_cnt = 0; pop_cnt = 0; ready_i = 1'b1;
      arm(16'd6, 1'b0);
      for (int c = 0; c < 6; c++) begin
         frame_i = 1'b1; data_i = 32'h700 + c; exp_q.push_back({(c == 5), 32'h700 + c});
         tick();
      end
      frame_i = 1'b0;
      checks++;
      if (pop_cnt != 5) begin failures++; $display("FAIL b2b_rate got pops=%0d required 5", pop_cnt); end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done_o) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen || busy_o !== 1'b0) begin failures++; $display("FAIL b2b_done got seen=%0b busy=%0b required 1 0", seen, busy_o); end
      arm(16'd1, 1'b0);
      checks++;
      if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_rearm got busy=%0b required 1", busy_o); end
      frame_i = 1'b1; data_i = 32'h7FF; exp_q.push_back({1'b1, 32'h7FF});
      tick();
      frame_i = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok || done_cnt != 2 || count_o !== 16'd1)
         begin failures++; $display("FAIL b2b_finish got ok=%0b done=%0d cnt=%0d required 1 2 1", ok, done_cnt, count_o); end
   endtask

   task automatic test_reset_mid();
      ready_i = 1'b0;
      arm(16'd6, 1'b0);
      for (int c = 0; c < 3; c++) begin
         frame_i = 1'b1; data_i = 32'h800 + c;
         tick();
      end
      frame_i = 1'b0; rst_n = 1'b0;
      tick();
      checks++;
      if ({valid_o, data_o, last_o, busy_o, done_o, ovf_o, count_o} !== 53'h0)
         begin failures++; $display("FAIL reset_mid got v=%0b d=%h b=%0b cnt=%0d required all zero", valid_o, data_o, busy_o, count_o); end
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; arm_i = 1'b0; abort_i = 1'b0; len_i = '0; trig_mode_i = 1'b0;
      trig_i = 1'b0; data_i = '0; frame_i = 1'b0; ready_i = 1'b0;
      test_reset();
      test_immediate();
      test_trigger();
      test_overflow();
      test_full_pop();
      test_ignored_arm();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
